// File: rtl/tlb_xlate_resp_if.sv
// Address-translation bus between the MMU/CP0 side (master) and the TLB responder (slave):
// i/d lookup request-response pairs plus the CP0 TLB op handshake.
interface tlb_xlate_resp_if #(
  parameter int NENTRY = 16,
  parameter int ASID_W = 8
);
  localparam int IDX_W = $clog2(NENTRY);

  logic [ASID_W-1:0] asid;
  logic              k0_uncached;

  logic              i_req;
  logic [31:0]       i_vaddr;
  logic              i_resp_valid;
  logic [31:0]       i_paddr;
  logic              i_uncached;
  logic              i_refill;
  logic              i_invalid;

  logic              d_req;
  logic              d_we;
  logic [31:0]       d_vaddr;
  logic              d_resp_valid;
  logic [31:0]       d_paddr;
  logic              d_uncached;
  logic              d_refill;
  logic              d_invalid;
  logic              d_modified;

  logic              op_valid;
  logic              op_ready;
  logic [1:0]        op_code;
  logic [IDX_W-1:0]  op_index;
  logic [31:0]       op_entryhi;
  logic [31:0]       op_entrylo0;
  logic [31:0]       op_entrylo1;
  logic              op_done;
  logic [31:0]       res_index;
  logic [31:0]       res_entryhi;
  logic [31:0]       res_entrylo0;
  logic [31:0]       res_entrylo1;

  modport master (
    output asid, k0_uncached,
    output i_req, i_vaddr,
    input  i_resp_valid, i_paddr, i_uncached, i_refill, i_invalid,
    output d_req, d_we, d_vaddr,
    input  d_resp_valid, d_paddr, d_uncached, d_refill, d_invalid, d_modified,
    output op_valid, op_code, op_index, op_entryhi, op_entrylo0, op_entrylo1,
    input  op_ready, op_done, res_index, res_entryhi, res_entrylo0, res_entrylo1
  );

  modport slave (
    input  asid, k0_uncached,
    input  i_req, i_vaddr,
    output i_resp_valid, i_paddr, i_uncached, i_refill, i_invalid,
    input  d_req, d_we, d_vaddr,
    output d_resp_valid, d_paddr, d_uncached, d_refill, d_invalid, d_modified,
    input  op_valid, op_code, op_index, op_entryhi, op_entrylo0, op_entrylo1,
    output op_ready, op_done, res_index, res_entryhi, res_entrylo0, res_entrylo1
  );
endinterface

// File: rtl/tlb_xlate_resp.sv
// Fully-associative MIPS32 TLB responder: registered i/d translation plus TLBP/TLBR/TLBWI/TLBWR.
// Optional TLB_RANDOM_EN adds the Random register used as the TLBWR target index.
module tlb_xlate_resp #(
  parameter int NENTRY = 16,
  parameter int ASID_W = 8
) (
  input logic               clk,
  input logic               resetn,
  tlb_xlate_resp_if.slave   bus
);
  localparam int IDX_W = $clog2(NENTRY);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  typedef struct packed {
    logic [31:0] paddr;
    logic        unc;
    logic        refill;
    logic        invalid;
    logic        modified;
  } xlate_t;

  // Only valid/dirty/global bits are reset; tags and PFNs keep their last written value.
  logic [18:0]       vpn2_q [NENTRY];
  logic [ASID_W-1:0] asid_q [NENTRY];
  logic [19:0]       pfn0_q [NENTRY];
  logic [19:0]       pfn1_q [NENTRY];
  logic [2:0]        c0_q   [NENTRY];
  logic [2:0]        c1_q   [NENTRY];
  logic [NENTRY-1:0] g_q, v0_q, v1_q, d0_q, d1_q;

  state_t            state_q, state_d;
  logic              ready_q;
  logic [1:0]        code_q;
  logic [IDX_W-1:0]  idx_q;
  logic [18:0]       hi_vpn2_q;
  logic [ASID_W-1:0] hi_asid_q;
  logic [25:0]       lo0_q, lo1_q;
  logic [31:0]       res_index_q, res_hi_q, res_lo0_q, res_lo1_q;

  logic              i_valid_q, d_valid_q;
  xlate_t            i_res_q, d_res_q, i_x, d_x;

  logic              accept, wr_en, probe_hit;
  logic [IDX_W-1:0]  wr_idx, probe_idx;
  logic [31:0]       rd_hi, rd_lo0, rd_lo1;

  logic unused_bits;
  assign unused_bits = ^{bus.op_entryhi[12:ASID_W], bus.op_entrylo0[31:26], bus.op_entrylo1[31:26]};

  function automatic xlate_t xlate(input logic [31:0] va, input logic we,
                                   input logic [ASID_W-1:0] cur_asid, input logic k0_unc);
    xlate_t           r;
    logic             hit, v, d;
    logic [IDX_W-1:0] idx;
    logic [19:0]      pfn;
    logic [2:0]       c;
    r   = '0;
    hit = 1'b0;
    idx = '0;
    if (va[31:30] == 2'b10) begin
      r.paddr = {3'b000, va[28:0]};
      r.unc   = va[29] | k0_unc;
    end else begin
      // Descending scan so the lowest matching index is the one that sticks.
      for (int k = NENTRY - 1; k >= 0; k--) begin
        if (vpn2_q[k] == va[31:13] && (g_q[k] || asid_q[k] == cur_asid)) begin
          hit = 1'b1;
          idx = IDX_W'(k);
        end
      end
      pfn = va[12] ? pfn1_q[idx] : pfn0_q[idx];
      c   = va[12] ? c1_q[idx]   : c0_q[idx];
      v   = va[12] ? v1_q[idx]   : v0_q[idx];
      d   = va[12] ? d1_q[idx]   : d0_q[idx];
      if (!hit)             r.refill   = 1'b1;
      else if (!v)          r.invalid  = 1'b1;
      else if (we && !d)    r.modified = 1'b1;
      else begin
        r.paddr = {pfn, va[11:0]};
        r.unc   = (c != 3'd3);
      end
    end
    return r;
  endfunction

  always_comb begin
    i_x = xlate(bus.i_vaddr, 1'b0, bus.asid, bus.k0_uncached);
    d_x = xlate(bus.d_vaddr, bus.d_we, bus.asid, bus.k0_uncached);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      i_res_q   <= '0;
      d_res_q   <= '0;
    end else begin
      i_valid_q <= bus.i_req;
      d_valid_q <= bus.d_req;
      i_res_q   <= bus.i_req ? i_x : '0;
      d_res_q   <= bus.d_req ? d_x : '0;
    end
  end

  assign bus.i_resp_valid = i_valid_q;
  assign bus.i_paddr      = i_res_q.paddr;
  assign bus.i_uncached   = i_res_q.unc;
  assign bus.i_refill     = i_res_q.refill;
  assign bus.i_invalid    = i_res_q.invalid;
  assign bus.d_resp_valid = d_valid_q;
  assign bus.d_paddr      = d_res_q.paddr;
  assign bus.d_uncached   = d_res_q.unc;
  assign bus.d_refill     = d_res_q.refill;
  assign bus.d_invalid    = d_res_q.invalid;
  assign bus.d_modified   = d_res_q.modified;

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE: if (bus.op_valid && ready_q) begin
        accept  = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef TLB_RANDOM_EN
  logic [IDX_W-1:0] rand_q, rand_snap_q;

  // Free-running down-counter; power-of-two NENTRY makes the natural wrap land on NENTRY-1.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rand_q      <= IDX_W'(NENTRY - 1);
      rand_snap_q <= '0;
    end else begin
      rand_q <= rand_q - 1'b1;
      if (accept) rand_snap_q <= rand_q;
    end
  end

  assign wr_idx = (code_q == 2'b11) ? rand_snap_q : idx_q;
`else
  assign wr_idx = idx_q;
`endif

  assign wr_en       = (state_q == S_EXEC) && code_q[1];
  assign bus.op_ready = ready_q;
  assign bus.op_done  = (state_q == S_DONE);

  always_comb begin
    probe_hit = 1'b0;
    probe_idx = '0;
    for (int k = NENTRY - 1; k >= 0; k--) begin
      if (vpn2_q[k] == hi_vpn2_q && (g_q[k] || asid_q[k] == hi_asid_q)) begin
        probe_hit = 1'b1;
        probe_idx = IDX_W'(k);
      end
    end
    rd_hi                = '0;
    rd_hi[31:13]         = vpn2_q[idx_q];
    rd_hi[ASID_W-1:0]    = asid_q[idx_q];
    rd_lo0 = {6'b0, pfn0_q[idx_q], c0_q[idx_q], d0_q[idx_q], v0_q[idx_q], g_q[idx_q]};
    rd_lo1 = {6'b0, pfn1_q[idx_q], c1_q[idx_q], d1_q[idx_q], v1_q[idx_q], g_q[idx_q]};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b0;
      code_q      <= '0;
      idx_q       <= '0;
      hi_vpn2_q   <= '0;
      hi_asid_q   <= '0;
      lo0_q       <= '0;
      lo1_q       <= '0;
      res_index_q <= '0;
      res_hi_q    <= '0;
      res_lo0_q   <= '0;
      res_lo1_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == S_IDLE);
      if (accept) begin
        code_q    <= bus.op_code;
        idx_q     <= bus.op_index;
        hi_vpn2_q <= bus.op_entryhi[31:13];
        hi_asid_q <= bus.op_entryhi[ASID_W-1:0];
        lo0_q     <= bus.op_entrylo0[25:0];
        lo1_q     <= bus.op_entrylo1[25:0];
      end
      if (state_q == S_EXEC) begin
        case (code_q)
          2'b00: res_index_q <= probe_hit ? {{(32-IDX_W){1'b0}}, probe_idx} : 32'h8000_0000;
          2'b01: begin
            res_hi_q  <= rd_hi;
            res_lo0_q <= rd_lo0;
            res_lo1_q <= rd_lo1;
          end
          2'b11:   res_index_q <= {{(32-IDX_W){1'b0}}, wr_idx};
          default: ;
        endcase
      end
    end
  end

  assign bus.res_index    = res_index_q;
  assign bus.res_entryhi  = res_hi_q;
  assign bus.res_entrylo0 = res_lo0_q;
  assign bus.res_entrylo1 = res_lo1_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      g_q  <= '0;
      v0_q <= '0;
      v1_q <= '0;
      d0_q <= '0;
      d1_q <= '0;
    end else if (wr_en) begin
      g_q[wr_idx]  <= lo0_q[0] & lo1_q[0];
      v0_q[wr_idx] <= lo0_q[1];
      v1_q[wr_idx] <= lo1_q[1];
      d0_q[wr_idx] <= lo0_q[2];
      d1_q[wr_idx] <= lo1_q[2];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      vpn2_q[wr_idx] <= hi_vpn2_q;
      asid_q[wr_idx] <= hi_asid_q;
      pfn0_q[wr_idx] <= lo0_q[25:6];
      pfn1_q[wr_idx] <= lo1_q[25:6];
      c0_q[wr_idx]   <= lo0_q[5:3];
      c1_q[wr_idx]   <= lo1_q[5:3];
    end
  end
endmodule
